// File: rtl/aes_cipher_top.sv
// ---------------------------------------------------------------------------
// aes_cipher_top -- iterative AES-128 encryption core, one round per clock.
//
// A single-cycle ld pulse captures key and text_in and performs the initial
// AddRoundKey. Ten further clocks run rounds 1..10 with on-the-fly key
// expansion, after which text_out carries the ciphertext and done pulses for
// one cycle. A new ld at any time (including the final-round edge) restarts
// the core with the new inputs.
//
// Ports:
//   clk      system clock, rising edge
//   rst      asynchronous active-low reset
//   ld       load strobe, starts (or restarts) an encryption
//   done     one-cycle pulse, text_out holds a fresh ciphertext
//   key      128-bit cipher key, key[127:120] is byte 0
//   text_in  128-bit plaintext, byte 0 in [127:120], state column-major
//   text_out 128-bit ciphertext, held until the next result
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module aes_cipher_top (
   input  logic         clk,
   input  logic         rst,
   input  logic         ld,
   output logic         done,
   input  logic [127:0] key,
   input  logic [127:0] text_in,
   output logic [127:0] text_out
);

   // Standard AES S-box, entry 0 in the most significant byte.
   localparam logic [2047:0] SBOX_ROM = {
      128'h637c777bf26b6fc53001672bfed7ab76,
      128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115,
      128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84,
      128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8,
      128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973,
      128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479,
      128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
      128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df,
      128'h8ca1890dbfe6426841992d0fb054bb16
   };

   typedef enum logic {ST_IDLE, ST_RUN} state_t;

   state_t       st_q, st_d;
   logic [127:0] state_q;
   logic [127:0] rkey_q;
   logic [127:0] text_out_q;
   logic [3:0]   rnd_q;
   logic         done_q;
   logic         last_round;
   logic         finish;
   logic [127:0] rkey_next;
   logic [127:0] sr;
   logic [127:0] mix;
   logic [127:0] round_out;
   logic [31:0]  kw_temp;

   // Byte b sits at bit offset (255-b)*8 = {~b,3'b000}.
   function automatic logic [7:0] sbox(input logic [7:0] b);
      return SBOX_ROM[{~b, 3'b000} +: 8];
   endfunction

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] rcon(input logic [3:0] r);
      case (r)
         4'd1:    return 8'h01;
         4'd2:    return 8'h02;
         4'd3:    return 8'h04;
         4'd4:    return 8'h08;
         4'd5:    return 8'h10;
         4'd6:    return 8'h20;
         4'd7:    return 8'h40;
         4'd8:    return 8'h80;
         4'd9:    return 8'h1b;
         4'd10:   return 8'h36;
         default: return 8'h00;
      endcase
   endfunction

   function automatic logic [31:0] mix_col(input logic [31:0] col);
      logic [7:0] a0, a1, a2, a3;
      a0 = col[31:24];
      a1 = col[23:16];
      a2 = col[15:8];
      a3 = col[7:0];
      return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
              a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
              a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
              xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
   endfunction

   assign last_round = (rnd_q == 4'd10);

   // Round datapath: key expansion, SubBytes+ShiftRows, MixColumns, AddRoundKey.
   always_comb begin
      kw_temp = {sbox(rkey_q[23:16]) ^ rcon(rnd_q), sbox(rkey_q[15:8]),
                 sbox(rkey_q[7:0]), sbox(rkey_q[31:24])};
      rkey_next[127:96] = rkey_q[127:96] ^ kw_temp;
      rkey_next[95:64]  = rkey_q[95:64]  ^ rkey_next[127:96];
      rkey_next[63:32]  = rkey_q[63:32]  ^ rkey_next[95:64];
      rkey_next[31:0]   = rkey_q[31:0]   ^ rkey_next[63:32];

      // byte 4c+r is row r, column c; row r rotates left by r columns
      sr = '0;
      for (int unsigned c = 0; c < 4; c++) begin
         for (int unsigned r = 0; r < 4; r++) begin
            sr[127 - 8*(4*c + r) -: 8] = sbox(state_q[127 - 8*(4*((c + r) % 4) + r) -: 8]);
         end
      end

      mix = '0;
      for (int unsigned c = 0; c < 4; c++) begin
         mix[127 - 32*c -: 32] = mix_col(sr[127 - 32*c -: 32]);
      end

      round_out = (last_round ? sr : mix) ^ rkey_next;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) st_q <= ST_IDLE;
      else      st_q <= st_d;
   end

   // ld takes priority over completion, so a load on the last-round edge
   // suppresses that block's result.
   always_comb begin
      st_d   = st_q;
      finish = 1'b0;
      if (ld) begin
         st_d = ST_RUN;
      end else if (st_q == ST_RUN && last_round) begin
         st_d   = ST_IDLE;
         finish = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= '0;
         rkey_q     <= '0;
         text_out_q <= '0;
         rnd_q      <= '0;
         done_q     <= 1'b0;
      end else begin
         done_q <= finish;
         if (ld) begin
            state_q <= text_in ^ key;
            rkey_q  <= key;
            rnd_q   <= 4'd1;
         end else if (st_q == ST_RUN) begin
            rkey_q <= rkey_next;
            if (last_round) begin
               text_out_q <= round_out;
               rnd_q      <= '0;
            end else begin
               state_q <= round_out;
               rnd_q   <= rnd_q + 4'd1;
            end
         end
      end
   end

   assign done     = done_q;
   assign text_out = text_out_q;

endmodule

// File: tb/tb_aes_cipher_top.sv
// ---------------------------------------------------------------------------
// tb_aes_cipher_top -- scoreboard bench for aes_cipher_top.
// The driver pushes the expected ciphertext and load cycle of each block; a
// negedge monitor pops on every done and checks value, latency and pulse
// width, and checks that text_out holds its last value otherwise.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_aes_cipher_top;

   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic         ld  = 1'b0;
   logic         done;
   logic [127:0] key = '0;
   logic [127:0] text_in = '0;
   logic [127:0] text_out;

   always #5 clk = ~clk;

   aes_cipher_top dut (
      .clk      (clk),
      .rst      (rst),
      .ld       (ld),
      .done     (done),
      .key      (key),
      .text_in  (text_in),
      .text_out (text_out)
   );

   typedef struct {
      logic [127:0] exp;
      int unsigned  issue;
   } exp_t;

   exp_t         exp_q[$];
   int unsigned  cyc = 0;
   int unsigned  checks = 0;
   int unsigned  passed = 0;
   logic [127:0] exp_hold = '0;
   logic         prev_done = 1'b0;
   logic [7:0]   sb [256];

   localparam logic [127:0] K_C1 = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] P_C1 = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] C_C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] K_B  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] P_B  = 128'h3243f6a8885a308d313198a2e0370734;
   localparam logic [127:0] C_B  = 128'h3925841d02dc09fbdc118597196a0b32;
   localparam logic [127:0] C_Z  = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string nm, input logic [127:0] act, input logic [127:0] req);
      checks++;
      if (act === req) passed++;
      else $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, req, cyc);
   endtask

   // ---------------- reference model (FIPS-197, byte matrices) ----------------
   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p = '0;
      logic [7:0] x = a;
      for (int unsigned i = 0; i < 8; i++) begin
         if (b[i]) p ^= x;
         x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      end
      return p;
   endfunction

   // S-box from the definition: multiplicative inverse then affine map.
   task automatic build_sbox();
      for (int unsigned x = 0; x < 256; x++) begin
         logic [7:0] inv = '0;
         logic [7:0] s, t;
         for (int unsigned y = 1; y < 256; y++)
            if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
         s = inv;
         t = inv;
         repeat (4) begin
            t = {t[6:0], t[7]};
            s ^= t;
         end
         sb[x] = s ^ 8'h63;
      end
   endtask

   function automatic logic [127:0] aes_ref(input logic [127:0] k, input logic [127:0] p);
      logic [7:0]   w [44][4];
      logic [7:0]   s [4][4];
      logic [7:0]   t [4][4];
      logic [7:0]   tmp [4];
      logic [7:0]   rc = 8'h01;
      logic [127:0] out = '0;
      for (int unsigned i = 0; i < 4; i++)
         for (int unsigned j = 0; j < 4; j++)
            w[i][j] = k[127 - 8*(4*i + j) -: 8];
      for (int unsigned i = 4; i < 44; i++) begin
         for (int unsigned j = 0; j < 4; j++) tmp[j] = w[i-1][j];
         if (i % 4 == 0) begin
            for (int unsigned j = 0; j < 4; j++) tmp[j] = sb[w[i-1][(j + 1) % 4]];
            tmp[0] ^= rc;
            rc = gmul(rc, 8'h02);
         end
         for (int unsigned j = 0; j < 4; j++) w[i][j] = w[i-4][j] ^ tmp[j];
      end
      for (int unsigned r = 0; r < 4; r++)
         for (int unsigned c = 0; c < 4; c++)
            s[r][c] = p[127 - 8*(4*c + r) -: 8] ^ w[c][r];
      for (int unsigned rnd = 1; rnd <= 10; rnd++) begin
         for (int unsigned r = 0; r < 4; r++)
            for (int unsigned c = 0; c < 4; c++)
               t[r][c] = sb[s[r][(c + r) % 4]];
         for (int unsigned r = 0; r < 4; r++)
            for (int unsigned c = 0; c < 4; c++) begin
               if (rnd < 10)
                  s[r][c] = gmul(8'h02, t[r][c]) ^ gmul(8'h03, t[(r+1)%4][c]) ^
                            t[(r+2)%4][c] ^ t[(r+3)%4][c];
               else
                  s[r][c] = t[r][c];
               s[r][c] ^= w[4*rnd + c][r];
            end
      end
      for (int unsigned r = 0; r < 4; r++)
         for (int unsigned c = 0; c < 4; c++)
            out[127 - 8*(4*c + r) -: 8] = s[r][c];
      return out;
   endfunction

   // ---------------- monitor ----------------
   always @(negedge clk) begin
      if (!rst) exp_hold = '0;
      if (done) begin
         check("done_width", 128'(prev_done), 128'd0);
         check("done_expected", 128'(exp_q.size() != 0), 128'd1);
         if (exp_q.size() != 0) begin
            exp_t e;
            e = exp_q.pop_front();
            check("text_out", text_out, e.exp);
            check("latency", 128'(cyc - e.issue), 128'd10);
            exp_hold = e.exp;
         end
      end else begin
         check("hold", text_out, exp_hold);
      end
      prev_done = done;
   end

   // ---------------- driver ----------------
   task automatic tick(input int unsigned n);
      repeat (n) begin
         @(posedge clk);
         #2;
      end
   endtask

   // Issues one ld edge; a still-pending block (load edge 10 or fewer cycles
   // earlier, i.e. not yet past its final round) is aborted.
   task automatic load(input logic [127:0] k, input logic [127:0] p, input logic [127:0] e);
      int unsigned le;
      exp_t        n;
      le = cyc + 1;
      if (exp_q.size() != 0 && (le - exp_q[$].issue) <= 10) void'(exp_q.pop_back());
      n.exp   = e;
      n.issue = le;
      exp_q.push_back(n);
      key     = k;
      text_in = p;
      ld      = 1'b1;
      tick(1);
      ld      = 1'b0;
   endtask

   function automatic logic [127:0] rnd128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   initial begin
      logic [127:0] k, p;
      build_sbox();

      tick(3);
      check("rst_text_out", text_out, '0);
      check("rst_done", 128'(done), 128'd0);
      rst = 1'b1;
      tick(50);

      load(K_C1, P_C1, C_C1);
      tick(12);

      load(K_B, P_B, C_B);
      key = rnd128();
      text_in = rnd128();
      tick(3);
      key = rnd128();
      text_in = rnd128();
      tick(10);

      load('0, '0, C_Z);
      tick(12);
      k = 128'hcafebabedeadbeefdeadbeef00000000;
      p = 128'hb4fde97f5fbfd5bc6ae980df7b110c5a;
      load(k, p, aes_ref(k, p));
      tick(12);

      // restart at cycle 5 after the first load
      load(K_C1, P_C1, C_C1);
      tick(4);
      load(K_B, P_B, C_B);
      tick(12);

      // reset in the middle of a block
      load(K_C1, P_C1, C_C1);
      tick(3);
      rst = 1'b0;
      exp_q.delete();
      #1;
      check("midrst_text_out", text_out, '0);
      check("midrst_done", 128'(done), 128'd0);
      tick(2);
      rst = 1'b1;
      tick(15);
      load(K_C1, P_C1, C_C1);
      tick(12);

      // ld on the final-round edge aborts; ld in the done cycle does not
      k = rnd128(); p = rnd128();
      load(k, p, aes_ref(k, p));
      tick(9);
      load(K_B, P_B, C_B);
      tick(10);
      k = rnd128(); p = rnd128();
      load(k, p, aes_ref(k, p));
      tick(12);

      // ld held for several cycles
      for (int unsigned i = 0; i < 3; i++) begin
         k = rnd128(); p = rnd128();
         load(k, p, aes_ref(k, p));
      end
      tick(12);

      for (int unsigned i = 0; i < 25; i++) begin
         k = rnd128(); p = rnd128();
         load(k, p, aes_ref(k, p));
         tick($urandom_range(0, 13));
      end
      tick(15);
      check("queue_drained", 128'(exp_q.size()), 128'd0);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached (cycle %0d)", cyc);
      $fatal(1);
   end

endmodule

// File: doc/aes_cipher_top.md
Name: aes_cipher_top

Overview:
Iterative AES-128 encryption core, one round per clock cycle. A one-cycle load pulse captures a 128-bit key and a 128-bit plaintext block. The core runs the 10 AES rounds with on-the-fly key expansion, then presents the ciphertext with a one-cycle done pulse. It is a standalone crypto datapath block driven by a host controller; it does no decryption.

Parameters:
None. AES-128 only: Nk=4, Nr=10.

Ports:
clk  input  1  system clock; all state updates on the rising edge
rst  input  1  asynchronous, active-low reset
ld  input  1  load strobe; sampled high for one cycle to start an encryption
done  output  1  one-cycle pulse; text_out holds a new ciphertext
key  input  128  cipher key, FIPS-197 byte order (key[127:120] = byte 0)
text_in  input  128  plaintext block, same byte order (text_in[127:120] = byte 0, state column-major)
text_out  output  128  ciphertext, same byte order; holds value until next result

Behaviour:
- One clock, clk. Reset is asynchronous and active-low on rst.
- While rst=0, immediately: text_out=0, done=0, busy=0, round counter=0, internal state and round-key registers=0.
- Idle: busy=0 and done=0. text_out keeps the last result, or 0 after reset.
- Load edge E0 (ld=1 at a rising edge), regardless of busy:
  - state <= text_in XOR key (initial AddRoundKey).
  - round key <= key.
  - round counter <= 1.
  - busy <= 1.
  - key and text_in are only sampled at this edge; later changes are ignored.
- Edges E1..E9, busy=1, counter r = 1..9:
  - round key <= next expanded key, using Rcon[r] = 01,02,04,08,10,20,40,80,1B,36.
  - state <= AddRoundKey(MixColumns(ShiftRows(SubBytes(state))), next key).
  - counter increments.
- Edge E10 (r = 10): final round without MixColumns.
  - text_out <= AddRoundKey(ShiftRows(SubBytes(state)), round key 10).
  - done <= 1, busy <= 0.
- done falls at E11. Latency: ciphertext visible and done high in the cycle after E10, i.e. 10 clocks after the load edge.
- Key expansion per FIPS-197:
  - w4 = w0 ^ SubWord(RotWord(w3)) ^ Rcon.
  - w5 = w1 ^ w4, w6 = w2 ^ w5, w7 = w3 ^ w6.
- S-box is the standard AES S-box. It may be a ROM table or combinational GF(2^8) inverse plus affine transform. It must be purely combinational within the round cycle.
- MixColumns uses the xtime-based GF(2^8) matrix [02 03 01 01] circulant, reduction polynomial 0x11B.
- ld asserted while busy aborts the current operation and restarts from E0 with the new inputs. No done is produced for the aborted block.
- ld held high for multiple cycles restarts every cycle; done appears 10 cycles after the last ld edge.
- ld coinciding with the E10 edge: the restart takes priority. text_out is not updated and done stays 0.
- Reset asserted mid-operation clears everything immediately. No done follows.
- Back-to-back use: ld may be asserted in the done cycle. That edge starts a new block and text_out keeps the previous result until the new E10.

Test Plan:
- Reset: hold rst=0, then release. Required: text_out=0, done=0, and done stays 0 with ld=0 for 50 cycles.
- FIPS-197 C.1: key=000102030405060708090a0b0c0d0e0f, text_in=00112233445566778899aabbccddeeff, ld pulse. Required: done exactly 10 cycles after the ld edge, text_out=69c4e0d86a7b0430d8cdb78070b4c55a, done width 1 cycle.
- FIPS-197 B: key=2b7e151628aed2a6abf7158809cf4f3c, text_in=3243f6a8885a308d313198a2e0370734. Required: text_out=3925841d02dc09fbdc118597196a0b32. Also change text_in/key after load and check the result is unaffected.
- All-zero key and plaintext: required text_out=66e94bd4ef8a2c3b884cfa59ca342b2e. Then key=cafebabedeadbeefdeadbeef00000000, text_in=b4fde97f5fbfd5bc6ae980df7b110c5a; text_out must match a software AES-128 model.
- Restart: issue ld with vector C.1, then ld with vector B at cycle 5. Required: single done 10 cycles after the second ld, text_out=3925841d..., and no done for the first block.
- Mid-operation reset: assert rst=0 at cycle 4 after ld. Required: text_out=0 and done=0 immediately, with no done afterwards. A subsequent C.1 run gives the correct result.
